// File: rtl/rhs_pkg.sv
// rhs_pkg: RHS command encoding and the channel tag carried alongside pipelined results
package rhs_pkg;
  localparam logic [1:0] RHS_CMD_CONVERT = 2'b00;
  localparam int RHS_PIPE_DEPTH = 2;
  typedef struct packed {
    logic       valid;
    logic [5:0] ch;
  } rhs_tag_t;
  function automatic logic [31:0] rhs_convert(input logic [5:0] ch);
    return {RHS_CMD_CONVERT, 8'h00, ch, 16'h0000};
  endfunction
endpackage

// File: rtl/rhs_tag_pipe.sv
// rhs_tag_pipe: DEPTH-deep tag shift register; one strobe pushes the new tag and exposes the oldest
module rhs_tag_pipe
  import rhs_pkg::*;
#(
  parameter int DEPTH = RHS_PIPE_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     strobe,
  input  rhs_tag_t din,
  output rhs_tag_t dout
);
  rhs_tag_t pipe [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (strobe) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/rhs_convert_sequencer.sv
// rhs_convert_sequencer: per-frame CONVERT scheduler with channel tagging and config insertion
module rhs_convert_sequencer
  import rhs_pkg::*;
#(
  parameter int N_CH       = 16,
  parameter int PIPE_DEPTH = RHS_PIPE_DEPTH,
  parameter int CH_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            frame_tick,
  input  logic            cfg_valid,
  input  logic [31:0]     cfg_data,
  output logic            cfg_ready,
  output logic            spi_start,
  output logic [31:0]     spi_cmd,
  input  logic            spi_busy,
  input  logic            spi_rx_valid,
  input  logic [31:0]     spi_rx,
  output logic            sample_valid,
  output logic [CH_W-1:0] sample_ch,
  output logic [15:0]     sample_data,
  output logic            frame_done,
  output logic            overrun
);
  localparam int N_CMD = N_CH + PIPE_DEPTH;
  localparam int K_W = $clog2(N_CMD);
  localparam logic [K_W-1:0] K_NCH = K_W'(N_CH);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_CMD - 1);
  typedef enum logic [2:0] {IDLE, CFG_ISSUE, CFG_WAIT, CONV_ISSUE, CONV_WAIT} state_t;
  state_t         state;
  logic [K_W-1:0] k;
  logic           tick_pend;
  logic           conv;
  logic           start_frame;
  logic           rx_take;
  logic           unused_rx;
  rhs_tag_t       tag_in;
  rhs_tag_t       tag_out;
  always_comb begin
    conv = state == CONV_ISSUE || state == CONV_WAIT;
    start_frame = state == IDLE && enable && (tick_pend || frame_tick);
    rx_take = state == CONV_WAIT && spi_rx_valid;
    tag_in = {k < K_NCH, 6'(k)};
  end
  assign unused_rx = ^spi_rx[31:16];
  // the tag of response k is pushed while the tag of command k-PIPE_DEPTH falls out
  rhs_tag_pipe #(.DEPTH(PIPE_DEPTH)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .strobe(rx_take),
    .din   (tag_in),
    .dout  (tag_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      tick_pend    <= 1'b0;
      overrun      <= 1'b0;
      cfg_ready    <= 1'b0;
      spi_start    <= 1'b0;
      spi_cmd      <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      frame_done   <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      cfg_ready    <= 1'b0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      tick_pend    <= start_frame ? 1'b0 : tick_pend | (frame_tick & ~conv);
      overrun      <= overrun | (frame_tick & (conv | tick_pend));
      case (state)
        IDLE: begin
          if (start_frame) begin
            state <= CONV_ISSUE;
            k     <= '0;
          end else if (cfg_valid) begin
            state <= CFG_ISSUE;
          end
        end
        CFG_ISSUE: begin
          if (!spi_busy) begin
            spi_cmd   <= cfg_data;
            spi_start <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= CFG_WAIT;
          end
        end
        CFG_WAIT: state <= spi_rx_valid ? IDLE : CFG_WAIT;
        CONV_ISSUE: begin
          if (!spi_busy) begin
            spi_cmd   <= rhs_convert(tag_in.valid ? tag_in.ch : 6'd0);
            spi_start <= 1'b1;
            state     <= CONV_WAIT;
          end
        end
        CONV_WAIT: begin
          if (spi_rx_valid) begin
            sample_valid <= tag_out.valid;
            sample_ch    <= CH_W'(tag_out.ch);
            sample_data  <= spi_rx[15:0];
            if (k == K_LAST) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              k     <= k + 1'b1;
              state <= CONV_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rhs_convert_sequencer.sv
// tb_rhs_convert_sequencer: two sequencers (16 and 1 channel) against a pipelined channel-echo SPI model
module tb_rhs_convert_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] cfg_data = 32'hDEADBEEF;
  int          ntest = 0;
  int          nfail = 0;
  always #5 clk = ~clk;
  // chip returns the result of the command issued two transfers earlier
  function automatic logic [15:0] echo(input logic [31:0] c);
    return c[31:30] == 2'b00 ? {8'hA5, 2'b00, c[21:16]} : 16'hFFFF;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        tick = 1'b0;
    logic        cfgv = 1'b0;
    logic        spi_start, spi_busy, spi_rx_valid, cfg_ready, sample_valid, frame_done, overrun;
    logic [31:0] spi_cmd, spi_rx, cur, h1, h2;
    logic [4:0]  sample_ch;
    logic [15:0] sample_data;
    int          cnt, n_start, n_samp, n_done, n_cfg, cfg_at, err, nxt;
    rhs_convert_sequencer #(.N_CH(g == 0 ? 16 : 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .frame_tick  (tick),
      .cfg_valid   (cfgv),
      .cfg_data    (cfg_data),
      .cfg_ready   (cfg_ready),
      .spi_start   (spi_start),
      .spi_cmd     (spi_cmd),
      .spi_busy    (spi_busy),
      .spi_rx_valid(spi_rx_valid),
      .spi_rx      (spi_rx),
      .sample_valid(sample_valid),
      .sample_ch   (sample_ch),
      .sample_data (sample_data),
      .frame_done  (frame_done),
      .overrun     (overrun)
    );
    always @(negedge clk) begin
      if (rst) begin
        spi_busy = 1'b0; spi_rx_valid = 1'b0; spi_rx = '0; cnt = 0; cur = '0; h1 = '0; h2 = '0;
        n_start = 0; n_samp = 0; n_done = 0; n_cfg = 0; cfg_at = -1; err = 0; nxt = 0;
      end else begin
        spi_rx_valid = 1'b0;
        if (spi_start) begin
          if (spi_busy) err++;
          n_start++; spi_busy = 1'b1; cnt = 3; cur = spi_cmd;
        end else if (spi_busy) begin
          if (spi_cmd != cur) err++;
          if (cnt == 0) begin
            spi_busy = 1'b0; spi_rx_valid = 1'b1; spi_rx = {16'h5A5A, echo(h2)}; h2 = h1; h1 = cur;
          end else cnt--;
        end
        if (sample_valid) begin
          n_samp++;
          if (sample_ch != 5'(nxt) || sample_data != {8'hA5, 2'b00, 6'(nxt)}) err++;
          nxt++;
        end
        if (frame_done) begin
          n_done++; nxt = 0;
          if (!sample_valid) err++;
        end
        if (cfg_ready) begin
          n_cfg++; cfg_at = n_done;
          if (!spi_start || spi_cmd != cfg_data) err++;
        end
      end
    end
  end
  typedef struct {
    logic en, tick, cfg;
    int   starts, samps, dones, cfgs, cfg_at;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (g_dut[0].cfg_ready) g_dut[0].cfgv = 1'b0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; g_dut[0].tick = 1'b0; g_dut[0].cfgv = 1'b0; g_dut[1].tick = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic pulse_tick(input int d);
    if (d == 0) g_dut[0].tick = 1'b1; else g_dut[1].tick = 1'b1;
    @(negedge clk);
    g_dut[0].tick = 1'b0; g_dut[1].tick = 1'b0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, int'({g_dut[0].spi_start, g_dut[0].cfg_ready, g_dut[0].sample_valid,
                            g_dut[0].frame_done, g_dut[0].overrun}), 0);
    chk({nm, "_cmd"}, int'(g_dut[0].spi_cmd), 0);
    chk({nm, "_smp"}, int'({g_dut[0].sample_ch, g_dut[0].sample_data}), 0);
  endtask
  task automatic chk_frame(input string nm, input int starts);
    chk({nm, "_starts"}, g_dut[0].n_start, starts);
    chk({nm, "_samps"}, g_dut[0].n_samp, 16);
    chk({nm, "_dones"}, g_dut[0].n_done, 1);
    chk({nm, "_err"}, g_dut[0].err, 0);
  endtask
  initial begin
    vecs[0] = '{en: 1, tick: 1, cfg: 0, starts: 18, samps: 16, dones: 1, cfgs: 0, cfg_at: -1};
    vecs[1] = '{en: 1, tick: 0, cfg: 1, starts: 1,  samps: 0,  dones: 0, cfgs: 1, cfg_at: 0};
    vecs[2] = '{en: 1, tick: 1, cfg: 1, starts: 19, samps: 16, dones: 1, cfgs: 1, cfg_at: 1};
    vecs[3] = '{en: 0, tick: 1, cfg: 0, starts: 0,  samps: 0,  dones: 0, cfgs: 0, cfg_at: -1};
    vecs[4] = '{en: 0, tick: 1, cfg: 1, starts: 1,  samps: 0,  dones: 0, cfgs: 1, cfg_at: 0};
    // reset holds everything at zero even with requests asserted
    g_dut[0].tick = 1'b1; g_dut[0].cfgv = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    for (int i = 0; i < 5; i++) begin
      do_reset();
      enable = vecs[i].en; g_dut[0].tick = vecs[i].tick; g_dut[0].cfgv = vecs[i].cfg;
      @(negedge clk);
      g_dut[0].tick = 1'b0;
      run(300);
      chk($sformatf("v%0d_starts", i), g_dut[0].n_start, vecs[i].starts);
      chk($sformatf("v%0d_samps", i), g_dut[0].n_samp, vecs[i].samps);
      chk($sformatf("v%0d_dones", i), g_dut[0].n_done, vecs[i].dones);
      chk($sformatf("v%0d_cfgs", i), g_dut[0].n_cfg, vecs[i].cfgs);
      chk($sformatf("v%0d_cfg_at", i), g_dut[0].cfg_at, vecs[i].cfg_at);
      chk($sformatf("v%0d_err", i), g_dut[0].err, 0);
      chk($sformatf("v%0d_overrun", i), int'(g_dut[0].overrun), 0);
    end
    // pending tick launches once enable returns
    do_reset();
    enable = 1'b0;
    pulse_tick(0);
    run(20);
    chk("en_hold_starts", g_dut[0].n_start, 0);
    enable = 1'b1;
    run(300);
    chk_frame("en_resume", 18);
    // config first, then a normal frame
    do_reset();
    g_dut[0].cfgv = 1'b1;
    run(30);
    chk("cfg_then_cfgs", g_dut[0].n_cfg, 1);
    pulse_tick(0);
    run(300);
    chk_frame("cfg_then", 19);
    // second tick at command 5 flags overrun, frame unaffected
    do_reset();
    pulse_tick(0);
    for (int i = 0; i < 500 && g_dut[0].n_start < 6; i++) @(negedge clk);
    chk("ovr_wait", g_dut[0].n_start, 6);
    pulse_tick(0);
    chk("ovr_set", int'(g_dut[0].overrun), 1);
    run(300);
    chk("ovr_sticky", int'(g_dut[0].overrun), 1);
    chk_frame("ovr", 18);
    // one-cycle reset at command 7
    do_reset();
    pulse_tick(0);
    for (int i = 0; i < 500 && g_dut[0].n_start < 8; i++) @(negedge clk);
    chk("rstmid_wait", g_dut[0].n_start, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rstmid");
    run(40);
    chk("rstmid_idle", g_dut[0].n_start, 0);
    pulse_tick(0);
    run(300);
    chk_frame("rstmid", 18);
    // single-channel instance
    do_reset();
    pulse_tick(1);
    run(100);
    chk("n1_starts", g_dut[1].n_start, 3);
    chk("n1_samps", g_dut[1].n_samp, 1);
    chk("n1_dones", g_dut[1].n_done, 1);
    chk("n1_err", g_dut[1].err, 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
